// File: rtl/maclaurin_pipe.sv
// Fully pipelined ln(1+x) evaluator using a TERMS-term Maclaurin series on signed Q(WIDTH-FRAC).FRAC data.
// Define MACLAURIN_ROUND_EN to round every FRAC shift to nearest instead of truncating toward -inf.
module maclaurin_pipe #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 30,
    parameter int TERMS = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic             start_export,
    input  logic [WIDTH-1:0] x_export,
    output logic [WIDTH-1:0] ln_export,
    output logic [1:0]       status_export,
    output logic [CNT_W-1:0] count_export
);

    typedef logic signed [WIDTH-1:0] word_t;

    localparam word_t HALF = word_t'(64'sd1 <<< (FRAC - 1));
    localparam logic signed [2*WIDTH-1:0] RND = (2*WIDTH)'(1) << (FRAC - 1);

    // Full-precision product, optionally rounded, shifted back to Q format and reduced to WIDTH bits.
    function automatic word_t mul_shr(input word_t a, input word_t b);
        logic signed [2*WIDTH-1:0] p;
        p = (2*WIDTH)'(a) * (2*WIDTH)'(b);
`ifdef MACLAURIN_ROUND_EN
        p = p + RND;
`endif
        return WIDTH'(p >>> FRAC);
    endfunction

    // round(2^FRAC / k), evaluated only at elaboration.
    function automatic word_t recip(input int k);
        longint num;
        num = (longint'(1) << FRAC) + longint'(k / 2);
        return word_t'(num / longint'(k));
    endfunction

    // Index 0 is the input stage, index j (1..TERMS-1) adds term k=j+1, index TERMS applies the error mux.
    word_t x_q   [TERMS];
    word_t pw_q  [TERMS];
    word_t acc_q [TERMS+1];
    logic  oor_q [TERMS+1];
    logic  vld_q [TERMS+1];

    word_t            ln_q;
    logic             done_q;
    logic             err_q;
    logic [CNT_W-1:0] count_q;

    word_t x_in;
    assign x_in = word_t'(x_export);

    always_ff @(posedge clk_clk) begin
        vld_q[0] <= reset_reset ? 1'b0 : start_export;
        x_q[0]   <= x_in;
        pw_q[0]  <= x_in;
        acc_q[0] <= x_in;
        oor_q[0] <= (x_in > HALF) || (x_in < -HALF);
    end

    generate
        for (genvar gi = 1; gi < TERMS; gi++) begin : g_term
            localparam word_t R_K = recip(gi + 1);
            word_t pw_next;
            word_t term_next;

            always_comb begin
                pw_next   = mul_shr(pw_q[gi-1], x_q[gi-1]);
                term_next = mul_shr(pw_next, R_K);
            end

            always_ff @(posedge clk_clk) begin
                vld_q[gi] <= reset_reset ? 1'b0 : vld_q[gi-1];
                x_q[gi]   <= x_q[gi-1];
                pw_q[gi]  <= pw_next;
                oor_q[gi] <= oor_q[gi-1];
            end

            // Series alternates: odd powers add, even powers subtract.
            if (((gi + 1) % 2) == 1) begin : g_odd
                always_ff @(posedge clk_clk) acc_q[gi] <= acc_q[gi-1] + term_next;
            end else begin : g_even
                always_ff @(posedge clk_clk) acc_q[gi] <= acc_q[gi-1] - term_next;
            end
        end
    endgenerate

    always_ff @(posedge clk_clk) begin
        vld_q[TERMS] <= reset_reset ? 1'b0 : vld_q[TERMS-1];
        oor_q[TERMS] <= oor_q[TERMS-1];
        acc_q[TERMS] <= oor_q[TERMS-1] ? '0 : acc_q[TERMS-1];
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            ln_q   <= '0;
        end else begin
            done_q <= vld_q[TERMS];
            err_q  <= vld_q[TERMS] && oor_q[TERMS];
            if (vld_q[TERMS]) begin
                ln_q <= acc_q[TERMS];
            end
        end
    end

    // Out-of-range events are counted as they leave the input stage.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            count_q <= '0;
        end else if (vld_q[0] && oor_q[0] && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign ln_export     = ln_q;
    assign status_export = {done_q, err_q};
    assign count_export  = count_q;

endmodule

// File: tb/tb_maclaurin_pipe.sv
// Scoreboard bench for maclaurin_pipe: a driver queues expected results, a negedge monitor checks them.
module tb_maclaurin_pipe;

    localparam int TERMS = 16;
    localparam int LAT   = TERMS + 1;

    logic        clk = 1'b0;
    logic        reset_reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] x = '0;
    logic [31:0] ln;
    logic [1:0]  status;
    logic [15:0] count;

    logic        start4 = 1'b0;
    logic [31:0] x4 = '0;
    logic [31:0] ln4;
    logic [1:0]  status4;
    logic [3:0]  count4;

    always #5 clk = ~clk;

    maclaurin_pipe dut (
        .clk_clk      (clk),
        .reset_reset  (reset_reset),
        .start_export (start),
        .x_export     (x),
        .ln_export    (ln),
        .status_export(status),
        .count_export (count)
    );

    maclaurin_pipe #(.CNT_W(4)) dut4 (
        .clk_clk      (clk),
        .reset_reset  (reset_reset),
        .start_export (start4),
        .x_export     (x4),
        .ln_export    (ln4),
        .status_export(status4),
        .count_export (count4)
    );

    typedef struct {
        real exp_ln;
        real tol;
        bit  err;
        int  due;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    logic rst_q = 1'b0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset_reset;
    end

    function automatic void check(input bit ok, input string name, input string detail);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: %s", name, detail);
        end
    endfunction

    // Monitor: one line per emitted result, plus idle/reset checks every cycle.
    initial begin
        logic [31:0] last_ln;
        exp_t        e;
        real         got, d;
        last_ln = '0;
        forever begin
            @(negedge clk);
            if (rst_q) begin
                check(ln === 32'd0 && status === 2'b00 && count === 16'd0 && count4 === 4'd0,
                      "reset_outputs",
                      $sformatf("cycle %0d ln=%h status=%b count=%0d count4=%0d, required all 0",
                                cyc, ln, status, count, count4));
                last_ln = '0;
            end else if (status[1] === 1'b1) begin
                if (sbq.size() == 0) begin
                    check(1'b0, "unexpected_done",
                          $sformatf("cycle %0d ln=%h with no sample outstanding", cyc, ln));
                end else begin
                    e = sbq.pop_front();
                    got = $itor($signed(ln)) / (2.0 ** 30);
                    $display("result cycle=%0d ln=%f err=%0d expected ln=%f err=%0d due=%0d",
                             cyc, got, status[0], e.exp_ln, e.err, e.due);
                    check(cyc == e.due, "latency",
                          $sformatf("done at cycle %0d, required cycle %0d", cyc, e.due));
                    check(status[0] === e.err, "error_flag",
                          $sformatf("cycle %0d error=%b, required %0d", cyc, status[0], e.err));
                    if (e.err) begin
                        check(ln === 32'd0, "ln_zero_on_error",
                              $sformatf("cycle %0d ln=%h, required 0", cyc, ln));
                    end else begin
                        d = got - e.exp_ln;
                        if (d < 0.0) d = -d;
                        check(d <= e.tol, "ln_value",
                              $sformatf("cycle %0d ln=%f, required %f within %e", cyc, got, e.exp_ln, e.tol));
                    end
                end
                last_ln = ln;
            end else begin
                check(status === 2'b00 && ln === last_ln, "idle_hold",
                      $sformatf("cycle %0d status=%b ln=%h, required status=00 ln=%h", cyc, status, ln, last_ln));
            end
        end
    end

    task automatic drive(input logic [31:0] xv, input bit push, input real tol);
        exp_t e;
        real  xr;
        start = 1'b1;
        x     = xv;
        if (push) begin
            xr       = $itor($signed(xv)) / (2.0 ** 30);
            e.err    = (xr > 0.5) || (xr < -0.5);
            e.exp_ln = e.err ? 0.0 : $ln(1.0 + xr);
            e.tol    = tol;
            e.due    = cyc + LAT + 1;
            sbq.push_back(e);
        end
    endtask

    task automatic send(input logic [31:0] xv, input bit push, input real tol);
        @(negedge clk);
        drive(xv, push, tol);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            start  = 1'b0;
            start4 = 1'b0;
        end
    endtask

    task automatic burst4(input int n);
        repeat (n) begin
            @(negedge clk);
            start4 = 1'b1;
            x4     = 32'h3000_0000;
        end
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int budget;
        repeat (3) @(negedge clk);
        reset_reset = 1'b0;

        // Zero in, zero out, exact.
        send(32'h0000_0000, 1'b1, 0.0);
        idle(20);

        // +0.5: ln(1.5) within 2^-20.
        send(32'h2000_0000, 1'b1, 2.0 ** -20);
        idle(20);

        // 140 back-to-back samples sweeping -0.5 .. ~+0.5, then bubbles.
        for (int i = 0; i < 140; i++) begin
            send(32'(-536870912 + i * 7724761), 1'b1, 2.0 ** -19);
        end
        idle(10);
        idle(20);

        // +0.75 is out of range: error result and counter step.
        send(32'h3000_0000, 1'b1, 0.0);
        @(negedge clk);
        start = 1'b0;
        check(count === 16'd0, "count_in_stage0",
              $sformatf("count=%0d, required 0", count));
        @(negedge clk);
        check(count === 16'd1, "count_incr",
              $sformatf("count=%0d, required 1", count));
        idle(20);
        check(count === 16'd1, "count_hold",
              $sformatf("count=%0d, required 1", count));

        // 4-bit counter saturates at 15.
        burst4(5);
        check(count4 === 4'd5, "count4_partial",
              $sformatf("count4=%0d, required 5", count4));
        burst4(15);
        check(count4 === 4'd15, "count4_saturate",
              $sformatf("count4=%0d, required 15", count4));
        idle(10);
        check(count4 === 4'd15, "count4_hold",
              $sformatf("count4=%0d, required 15", count4));
        idle(10);

        // Reset with 8 samples in flight; they must vanish, next sample runs normally.
        for (int i = 0; i < 8; i++) begin
            send(32'h0666_6666, 1'b0, 0.0);
        end
        @(negedge clk);
        start       = 1'b0;
        reset_reset = 1'b1;
        @(negedge clk);
        reset_reset = 1'b0;
        drive(32'h1000_0000, 1'b1, 2.0 ** -19);
        @(negedge clk);
        start = 1'b0;

        budget = 100;
        while (sbq.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check(sbq.size() == 0, "drain",
              $sformatf("%0d results still outstanding, required 0", sbq.size()));
        idle(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
